// File: rtl/plc_timer_bank.sv
`timescale 1ns/1ps
// plc_timer_bank
// Multi-channel IEC-style timer bank (TON / TOF / TP per channel) on a shared
// prescaled timebase, with a global MAN / AUTO / IDLE mode select.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   auto_sel     AUTO mode request
//   man_sel      MAN mode request (wins over auto_sel)
//   start        per-channel start/run command
//   cfg_we       configuration write strobe
//   cfg_ch       channel addressed by a configuration write
//   cfg_mode     00 TON, 01 TOF, 10 TP, 11 disabled
//   cfg_preset   preset in timer ticks
//   ctrl         per-channel control output
//   done         one-cycle expiry pulse per channel
//   busy         channel accumulator counting toward its preset
module plc_timer_bank #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 16,
  parameter int TICK_DIV   = 1,
  parameter int DEF_PRESET = 20,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             auto_sel,
  input  logic             man_sel,
  input  logic [NCH-1:0]   start,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_preset,
  output logic [NCH-1:0]   ctrl,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   busy
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MODE_TON = 2'b00;
  localparam logic [1:0] MODE_TOF = 2'b01;
  localparam logic [1:0] MODE_TP  = 2'b10;
  localparam logic [1:0] MODE_DIS = 2'b11;

  typedef enum logic [1:0] {EM_IDLE, EM_MAN, EM_AUTO} emode_t;

  emode_t           em;
  emode_t           em_q;
  logic [PS_W-1:0]  ps_cnt;
  logic             tick;

  logic [1:0]       mode   [NCH];
  logic [CNT_W-1:0] preset [NCH];
  logic [CNT_W-1:0] acc    [NCH];
  logic [CNT_W-1:0] acc_n  [NCH];

  logic [NCH-1:0]   q, q_n;
  logic [NCH-1:0]   done_r, done_n;
  logic [NCH-1:0]   busy_r, busy_n;
  logic [NCH-1:0]   start_d, rise, cfg_hit;

  assign em   = man_sel ? EM_MAN : (auto_sel ? EM_AUTO : EM_IDLE);
  assign rise = start & ~start_d;

  // Free-running timebase; with TICK_DIV=1 the counter stays at 0 and tick is
  // permanently high.
  assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end

  // Per-channel timer next state. Timers only run in AUTO and are held
  // cleared on the edge where the effective mode changes.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      acc_n[i]   = acc[i];
      q_n[i]     = q[i];
      done_n[i]  = 1'b0;
      busy_n[i]  = 1'b0;
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      if (em != EM_AUTO || em != em_q || mode[i] == MODE_DIS) begin
        acc_n[i] = '0;
        q_n[i]   = 1'b0;
      end else begin
        case (mode[i])
          MODE_TON: begin
            if (!start[i]) begin
              acc_n[i] = '0;
              q_n[i]   = 1'b0;
            end else if (preset[i] == '0) begin
              q_n[i]    = 1'b1;
              done_n[i] = ~q[i];
            end else if (tick && acc[i] < preset[i]) begin
              acc_n[i] = acc[i] + CNT_W'(1);
              if (acc[i] + CNT_W'(1) == preset[i]) begin
                q_n[i]    = 1'b1;
                done_n[i] = 1'b1;
              end
            end
            busy_n[i] = start[i] & ~q_n[i];
          end
          MODE_TOF: begin
            if (start[i]) begin
              acc_n[i] = '0;
              q_n[i]   = 1'b1;
            end else if (q[i]) begin
              if (preset[i] == '0) begin
                q_n[i]    = 1'b0;
                done_n[i] = 1'b1;
              end else if (tick) begin
                acc_n[i] = acc[i] + CNT_W'(1);
                if (acc[i] + CNT_W'(1) == preset[i]) begin
                  q_n[i]    = 1'b0;
                  done_n[i] = 1'b1;
                end
              end
            end
            busy_n[i] = q_n[i] & ~start[i];
          end
          MODE_TP: begin
            // Retriggers are ignored while the pulse is running.
            if (q[i]) begin
              if (tick) begin
                acc_n[i] = acc[i] + CNT_W'(1);
                if (acc[i] + CNT_W'(1) == preset[i]) begin
                  q_n[i]    = 1'b0;
                  done_n[i] = 1'b1;
                end
              end
            end else if (rise[i] && preset[i] != '0) begin
              q_n[i]   = 1'b1;
              acc_n[i] = '0;
            end
            busy_n[i] = q_n[i];
          end
          default: ;
        endcase
      end
    end
  end

  // A configuration write takes precedence over any timer event on the same
  // channel, including an expiry landing on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_q    <= EM_IDLE;
      start_d <= '0;
      q       <= '0;
      done_r  <= '0;
      busy_r  <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode[i]   <= MODE_TON;
        preset[i] <= CNT_W'(DEF_PRESET);
        acc[i]    <= '0;
      end
    end else begin
      em_q    <= em;
      start_d <= start;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_hit[i]) begin
          mode[i]   <= cfg_mode;
          preset[i] <= cfg_preset;
          acc[i]    <= '0;
          q[i]      <= 1'b0;
          done_r[i] <= 1'b0;
          busy_r[i] <= 1'b0;
        end else begin
          acc[i]    <= acc_n[i];
          q[i]      <= q_n[i];
          done_r[i] <= done_n[i];
          busy_r[i] <= busy_n[i];
        end
      end
    end
  end

  // MAN is a combinational pass-through, so it is gated by rst directly to
  // keep the outputs low for the whole reset.
  always_comb begin
    ctrl = '0;
    done = '0;
    busy = '0;
    if (!rst) begin
      case (em)
        EM_MAN: begin
          for (int i = 0; i < NCH; i++)
            ctrl[i] = start[i] && (mode[i] != MODE_DIS);
        end
        EM_AUTO: begin
          ctrl = q;
          done = done_r;
          busy = busy_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plc_timer_bank.sv
`timescale 1ns/1ps
// Testbench for plc_timer_bank: a TICK_DIV=1 instance (dut) and a TICK_DIV=4
// instance (dut4) share all inputs; expected outputs are queued per cycle.
module tb_plc_timer_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        auto_sel = 1'b0;
  logic        man_sel = 1'b0;
  logic [3:0]  start = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_preset = '0;
  logic [3:0]  ctrl, done, busy;
  logic [3:0]  ctrl4, done4, busy4;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [3:0] done;
    logic [3:0] busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  plc_timer_bank #(.NCH(4), .CNT_W(16), .TICK_DIV(1), .DEF_PRESET(20)) dut (
    .clk(clk), .rst(rst), .auto_sel(auto_sel), .man_sel(man_sel),
    .start(start), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_preset(cfg_preset), .ctrl(ctrl), .done(done), .busy(busy)
  );

  plc_timer_bank #(.NCH(4), .CNT_W(16), .TICK_DIV(4), .DEF_PRESET(20)) dut4 (
    .clk(clk), .rst(rst), .auto_sel(auto_sel), .man_sel(man_sel),
    .start(start), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_preset(cfg_preset), .ctrl(ctrl4), .done(done4), .busy(busy4)
  );

  task automatic do_reset();
    start = '0; auto_sel = 1'b0; man_sel = 1'b0; cfg_we = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] md,
                           input logic [15:0] pr);
    cfg_ch = ch; cfg_mode = md; cfg_preset = pr; cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic enter_auto();
    man_sel = 1'b0; auto_sel = 1'b1; start = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Mid-count async reset; ch0 preset is changed to 5 first so the following
  // TON test proves the default preset came back.
  task automatic test_reset();
    do_reset();
    enter_auto();
    cfg_write(2'd0, 2'b00, 16'd5);
    start = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      e = {4'b0000, 4'b0000, 4'b0001}; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if ({ctrl, done, busy} !== e) begin
        n_err++;
        $display("FAIL reset_precount k=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                 k, ctrl, done, busy, e.ctrl, e.done, e.busy);
      end
    end
    #3 rst = 1'b1;
    e = '0; sb.push_back(e);
    #1;
    e = sb.pop_front(); n_vec++;
    if ({ctrl, done, busy} !== e) begin
      n_err++;
      $display("FAIL reset_async ctrl/done/busy got %b/%b/%b want %b/%b/%b",
               ctrl, done, busy, e.ctrl, e.done, e.busy);
    end
    man_sel = 1'b1; start = 4'b1111;
    e = '0; sb.push_back(e);
    #1;
    e = sb.pop_front(); n_vec++;
    if ({ctrl, done, busy} !== e) begin
      n_err++;
      $display("FAIL reset_man_gate ctrl/done/busy got %b/%b/%b want %b/%b/%b",
               ctrl, done, busy, e.ctrl, e.done, e.busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    e = {4'b1111, 4'b0000, 4'b0000}; sb.push_back(e);
    #1;
    e = sb.pop_front(); n_vec++;
    if ({ctrl, done, busy} !== e) begin
      n_err++;
      $display("FAIL reset_release_man ctrl/done/busy got %b/%b/%b want %b/%b/%b",
               ctrl, done, busy, e.ctrl, e.done, e.busy);
    end
  endtask

  task automatic test_ton();
    enter_auto();
    start = 4'b0001;
    for (int k = 1; k <= 22; k++) begin
      e = {{3'b000, k >= 20}, {3'b000, k == 20}, {3'b000, k < 20}};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if ({ctrl, done, busy} !== e) begin
        n_err++;
        $display("FAIL ton k=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                 k, ctrl, done, busy, e.ctrl, e.done, e.busy);
      end
    end
    start = 4'b0000;
    e = '0; sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front(); n_vec++;
    if ({ctrl, done, busy} !== e) begin
      n_err++;
      $display("FAIL ton_release ctrl/done/busy got %b/%b/%b want %b/%b/%b",
               ctrl, done, busy, e.ctrl, e.done, e.busy);
    end
  endtask

  task automatic test_man_idle();
    logic [3:0] pats [4] = '{4'b0010, 4'b0000, 4'b1011, 4'b0110};
    do_reset();
    man_sel = 1'b1;
    for (int both = 0; both < 2; both++) begin
      auto_sel = (both == 1);
      for (int p = 0; p < 4; p++) begin
        start = pats[p];
        e = {pats[p], 4'b0000, 4'b0000}; sb.push_back(e);
        #1;
        e = sb.pop_front(); n_vec++;
        if ({ctrl, done, busy} !== e) begin
          n_err++;
          $display("FAIL man both=%0d p=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                   both, p, ctrl, done, busy, e.ctrl, e.done, e.busy);
        end
      end
    end
    cfg_write(2'd1, 2'b11, 16'd0);
    start = 4'b1111;
    e = {4'b1101, 4'b0000, 4'b0000}; sb.push_back(e);
    #1;
    e = sb.pop_front(); n_vec++;
    if ({ctrl, done, busy} !== e) begin
      n_err++;
      $display("FAIL man_disabled ctrl/done/busy got %b/%b/%b want %b/%b/%b",
               ctrl, done, busy, e.ctrl, e.done, e.busy);
    end
    man_sel = 1'b0; auto_sel = 1'b0;
    for (int k = 0; k < 100; k++) begin
      e = '0; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if ({ctrl, done, busy} !== e) begin
        n_err++;
        $display("FAIL idle k=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                 k, ctrl, done, busy, e.ctrl, e.done, e.busy);
      end
    end
  endtask

  // ch2 TOF preset 5: high 3 cycles, low 2, re-asserted 1, then low.
  task automatic test_tof();
    logic [0:11] s = 12'b111001000000;
    logic [0:11] c = 12'b111111111100;
    logic [0:11] b = 12'b000110111100;
    do_reset();
    enter_auto();
    cfg_write(2'd2, 2'b01, 16'd5);
    for (int k = 0; k < 12; k++) begin
      start[2] = s[k];
      e = {{1'b0, c[k], 2'b00}, {1'b0, k == 10, 2'b00}, {1'b0, b[k], 2'b00}};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if ({ctrl, done, busy} !== e) begin
        n_err++;
        $display("FAIL tof k=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                 k, ctrl, done, busy, e.ctrl, e.done, e.busy);
      end
    end
  endtask

  // ch3 TP preset 8 pulsed at cycles 0,2,4; then preset 0 gives no pulse.
  task automatic test_tp();
    logic [0:10] s = 11'b10101000000;
    logic [0:10] c = 11'b11111111000;
    do_reset();
    enter_auto();
    cfg_write(2'd3, 2'b10, 16'd8);
    for (int k = 0; k < 11; k++) begin
      start[3] = s[k];
      e = {{c[k], 3'b000}, {k == 8, 3'b000}, {c[k], 3'b000}};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if ({ctrl, done, busy} !== e) begin
        n_err++;
        $display("FAIL tp k=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                 k, ctrl, done, busy, e.ctrl, e.done, e.busy);
      end
    end
    cfg_write(2'd3, 2'b10, 16'd0);
    for (int k = 0; k < 6; k++) begin
      start[3] = (k == 0);
      e = '0; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front(); n_vec++;
      if ({ctrl, done, busy} !== e) begin
        n_err++;
        $display("FAIL tp_preset0 k=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                 k, ctrl, done, busy, e.ctrl, e.done, e.busy);
      end
    end
  endtask

  // ch0 TON preset 4 with a config write landing on the expiry edge.
  task automatic test_cfg_collision();
    logic [0:8] bz = 9'b111011100;
    do_reset();
    enter_auto();
    cfg_write(2'd0, 2'b00, 16'd4);
    start = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      cfg_we = (k == 4);
      e = {{3'b000, k >= 8}, {3'b000, k == 8}, {3'b000, bz[k-1]}};
      sb.push_back(e);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      e = sb.pop_front(); n_vec++;
      if ({ctrl, done, busy} !== e) begin
        n_err++;
        $display("FAIL cfg_collision k=%0d ctrl/done/busy got %b/%b/%b want %b/%b/%b",
                 k, ctrl, done, busy, e.ctrl, e.done, e.busy);
      end
    end
  endtask

  // TICK_DIV=4 instance: ch1 TON preset 3 rises 9..12 clks after start; ch0
  // is rewritten at edge 6, restarting its count (rise 15..18).
  task automatic test_tickdiv();
    int r0 = 0, r1 = 0;
    logic d0 = 1'b0, d1 = 1'b0;
    do_reset();
    enter_auto();
    cfg_write(2'd1, 2'b00, 16'd3);
    cfg_write(2'd0, 2'b00, 16'd3);
    start = 4'b0011;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (ctrl4[0] && r0 == 0) begin r0 = n; d0 = done4[0]; end
      if (ctrl4[1] && r1 == 0) begin r1 = n; d1 = done4[1]; end
      cfg_we = (n == 5);
    end
    cfg_we = 1'b0;
    n_vec++;
    if (r1 < 9 || r1 > 12) begin
      n_err++; $display("FAIL tickdiv_ch1_rise got %0d want 9..12", r1);
    end
    n_vec++;
    if (d1 !== 1'b1) begin
      n_err++; $display("FAIL tickdiv_ch1_done got %b want 1", d1);
    end
    n_vec++;
    if (r0 < 15 || r0 > 18) begin
      n_err++; $display("FAIL tickdiv_ch0_cfg_restart got %0d want 15..18", r0);
    end
    n_vec++;
    if (d0 !== 1'b1) begin
      n_err++; $display("FAIL tickdiv_ch0_done got %b want 1", d0);
    end
  endtask

  initial begin
    test_reset();
    test_ton();
    test_man_idle();
    test_tof();
    test_tp();
    test_cfg_collision();
    test_tickdiv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
